bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares the single 16-bit address / 8-bit data memory bus between the CPU and a DMA/video
//  requester. Each requester issues a registered request and is acknowledged one cycle after
//  the memory strobe ends. Sits between the CPU bus pins and the memory/IO decoder; the top
//  level builds the tristate data bus from mem_wdata, mem_w and mem_r.
// PARAMETERS
//  ADDR_W         16  address width
//  DATA_W         8   data width
//  ACCESS_CYCLES  2   cycles mem_r/mem_w held per transfer (>=1)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  cpu_req    in   1       CPU transfer request; hold until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  last CPU read data (registered)
//  cpu_ack    out  1       one-cycle completion pulse
//  dma_req/dma_we/dma_addr/dma_wdata/dma_rdata/dma_ack   same as cpu_*, DMA side
//  mem_addr   out  ADDR_W  bus address
//  mem_wdata  out  DATA_W  bus write data
//  mem_rdata  in   DATA_W  bus read data, valid on last strobe cycle
//  mem_r      out  1       read strobe
//  mem_w      out  1       write strobe
//  grant      out  2       one-hot owner during ACCESS: [0]=CPU, [1]=DMA; 0 otherwise
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counter 0, last_grant=DMA. Reset mid-access aborts:
//    strobes low on next edge, no ack issued, rdata registers cleared.
//  - FSM IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req, select winner; latch addr/we/wdata into mem_*; assert mem_r (read) or
//    mem_w (write); set grant; cnt=ACCESS_CYCLES-1; go ACCESS. No req: stay, outputs 0.
//  - ACCESS: mem_* held stable. cnt!=0: decrement. cnt==0: on read, capture mem_rdata into
//    winner's rdata; drop strobes and grant; ack=1 for winner; go DONE.
//  - DONE: ack=0; reqs ignored; go IDLE. Requester drops req on the edge ack is seen.
//  - Latency: strobe high ACCESS_CYCLES cycles starting the cycle after IDLE sees req; ack
//    high the following cycle. Throughput: one transfer per ACCESS_CYCLES+2 cycles.
//  - mem_r and mem_w never high together. Writes leave *_rdata unchanged; *_rdata holds
//    until that requester's next read.
//  - req dropped during ACCESS: transfer still completes and ack still pulses.
//  - Changes to addr/we/wdata after grant are ignored until the next grant.
// CONFIGURATION
//  BUS_ARB_ROUND_ROBIN_EN undefined: fixed priority; DMA wins any tie (CPU may starve).
//  BUS_ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not in last_grant;
//    last_grant updates at each grant. After reset, the CPU wins the first tie.
//    A lone request is always granted.
// TESTING (ACCESS_CYCLES=2)
//  - CPU read 0x2000, mem_rdata=0xA5 -> mem_r high 2 cycles, addr 0x2000; cpu_ack 1 cycle;
//    cpu_rdata=0xA5; grant=01 during access.
//  - DMA write 0x1F00<=0x3C -> mem_w high 2 cycles, mem_wdata=0x3C; dma_ack; dma_rdata kept.
//  - Both req continuously, macro off -> DMA granted every transfer, cpu_ack never.
//    Macro on -> grants alternate CPU, DMA, CPU, ... with 4-cycle spacing.
//  - Reset asserted in the 1st strobe cycle -> next edge mem_r=0, no ack, state IDLE.
//  - ACCESS_CYCLES=1, back-to-back CPU reads -> strobe 1 cycle, ack every 3 cycles.

Source files
------------

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Shares one memory bus between a CPU and a DMA/video requester. The winning
//   request is latched into the bus registers and the read or write strobe is
//   held for ACCESS_CYCLES cycles. The winner's ack pulses for one cycle after
//   the strobe ends. One guard cycle follows before the next grant.
//
//   Build option: BUS_ARB_ROUND_ROBIN_EN
//     undefined : fixed priority. DMA wins every tie.
//     defined   : a tie goes to the requester that did not win the last grant.
//                 The CPU wins the first tie after reset.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cpu_req/we/addr/wdata CPU request and payload; hold req until cpu_ack
//   cpu_rdata, cpu_ack    last CPU read data; one-cycle completion pulse
//   dma_*                 same set of ports for the DMA side
//   mem_addr, mem_wdata   bus address and write data, latched at grant
//   mem_rdata             bus read data, sampled on the last strobe cycle
//   mem_r, mem_w          read and write strobes, never high together
//   grant                 one-hot owner during access ([0]=CPU, [1]=DMA)
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  // DMA / video requester
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  // memory / IO bus
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_r,
  output logic              mem_w,
  output logic [1:0]        grant
);

  // Counter width covers ACCESS_CYCLES-1 down to 0; ACCESS_CYCLES=1 still needs one bit.
  localparam int unsigned    CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic any_req_c;
  logic pick_dma_c;
  logic pick_we_c;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // 1 when the most recent grant went to DMA; reset value makes the CPU win the first tie.
  logic last_dma;
`endif

  // Winner selection for the grant decision made in IDLE
  always_comb begin
    any_req_c = cpu_req | dma_req;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    if (cpu_req && dma_req) begin
      pick_dma_c = ~last_dma;
    end else begin
      pick_dma_c = dma_req;
    end
`else
    pick_dma_c = dma_req;
`endif
    pick_we_c = pick_dma_c ? dma_we : cpu_we;
  end

  // Arbitration FSM with registered bus, ack and read-data outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_r     <= 1'b0;
      mem_w     <= 1'b0;
      grant     <= 2'b00;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_dma  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          if (any_req_c) begin
            mem_addr  <= pick_dma_c ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma_c ? dma_wdata : cpu_wdata;
            mem_r     <= ~pick_we_c;
            mem_w     <= pick_we_c;
            grant     <= pick_dma_c ? 2'b10 : 2'b01;
            cnt       <= CNT_LOAD;
            state     <= ACCESS;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_dma  <= pick_dma_c;
`endif
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Last strobe cycle: mem_rdata is valid now, so capture it for the owner.
            if (mem_r) begin
              if (grant[1]) begin
                dma_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            cpu_ack   <= grant[0];
            dma_ack   <= grant[1];
            mem_r     <= 1'b0;
            mem_w     <= 1'b0;
            grant     <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= DONE;
          end
        end

        DONE: begin
          // Guard cycle: the requester sees ack and drops req, so requests are ignored here.
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_r   <= 1'b0;
          mem_w   <= 1'b0;
          grant   <= 2'b00;
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
        end
      endcase
    end
  end

  // Bus invariants
  a_strobe_excl : assert property (@(posedge clk) disable iff (reset) !(mem_r && mem_w));
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) grant != 2'b11);
  a_strobe_owned: assert property (@(posedge clk) disable iff (reset)
                                   (mem_r || mem_w) == (grant != 2'b00));

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter. The main instance uses ACCESS_CYCLES=2.
//   A second instance uses ACCESS_CYCLES=1 for the back-to-back read cadence.
//   Hand-checked directed vectors are followed by multi-cycle corner sequences
//   (continuous contention, reset mid-access) and then randomized transfers.
//   The randomized transfers are checked against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int unsigned AC  = 2;
  localparam int unsigned AC1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT signals
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_r, mem_w;
  logic [1:0]  grant;

  // ACCESS_CYCLES=1 instance signals
  logic        u1_cpu_req, u1_cpu_we, u1_dma_req, u1_dma_we;
  logic [15:0] u1_cpu_addr, u1_dma_addr, u1_mem_addr;
  logic [7:0]  u1_cpu_wdata, u1_dma_wdata, u1_cpu_rdata, u1_dma_rdata, u1_mem_wdata, u1_mem_rdata;
  logic        u1_cpu_ack, u1_dma_ack, u1_mem_r, u1_mem_w;
  logic [1:0]  u1_grant;

  bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_r(mem_r), .mem_w(mem_w), .grant(grant)
  );

  bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_CYCLES(AC1)) dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(u1_cpu_req), .cpu_we(u1_cpu_we), .cpu_addr(u1_cpu_addr), .cpu_wdata(u1_cpu_wdata),
    .cpu_rdata(u1_cpu_rdata), .cpu_ack(u1_cpu_ack),
    .dma_req(u1_dma_req), .dma_we(u1_dma_we), .dma_addr(u1_dma_addr), .dma_wdata(u1_dma_wdata),
    .dma_rdata(u1_dma_rdata), .dma_ack(u1_dma_ack),
    .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata),
    .mem_r(u1_mem_r), .mem_w(u1_mem_w), .grant(u1_grant)
  );

  // Memory stub: either a fixed byte or an address-derived byte
  logic       use_hash;
  logic [7:0] mem_data;

  function automatic logic [7:0] hash8(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always_comb mem_rdata = use_hash ? hash8(mem_addr) : mem_data;
  assign u1_mem_rdata = hash8(u1_mem_addr);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction-level model state
  bit         m_last_dma;
  logic [7:0] m_cpu_rd, m_dma_rd;

  function automatic bit model_pick_dma(input bit c, input bit d);
    if (c && d) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      return !m_last_dma;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  // What one transfer looked like on the bus
  typedef struct {
    logic [1:0]  grant;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        r;
    logic        w;
    int          strobes;
    int          lat;
    logic [1:0]  ack;
    int          ack_cyc;
    bit          stable;
    bit          both;
    bit          timeout;
    bit          ack_wide;
  } obs_t;

  // Watch one transfer until an ack (bounded), then one more cycle.
  task automatic xfer(input bit drop, input bit scramble, output obs_t o);
    bit got;
    got       = 1'b0;
    o.grant   = '0; o.addr = '0; o.wdata = '0; o.r = 1'b0; o.w = 1'b0;
    o.strobes = 0;  o.lat  = 0;  o.ack   = '0; o.ack_cyc = 0;
    o.stable  = 1'b1; o.both = 1'b0; o.timeout = 1'b0; o.ack_wide = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_r || mem_w) begin
        if (o.strobes == 0) begin
          o.lat = k; o.grant = grant; o.addr = mem_addr; o.wdata = mem_wdata;
          o.r = mem_r; o.w = mem_w;
          if (scramble) begin
            // Everything after grant must be ignored, including dropped requests.
            cpu_req   = 1'($urandom_range(0, 1));
            dma_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            dma_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 16'($urandom);
            dma_addr  = 16'($urandom);
            cpu_wdata = 8'($urandom);
            dma_wdata = 8'($urandom);
          end
        end else if (mem_addr !== o.addr || mem_wdata !== o.wdata || mem_r !== o.r ||
                     mem_w !== o.w || grant !== o.grant) begin
          o.stable = 1'b0;
        end
        if (mem_r && mem_w) o.both = 1'b1;
        o.strobes++;
      end
      if (cpu_ack || dma_ack) begin
        o.ack     = {dma_ack, cpu_ack};
        o.ack_cyc = cyc;
        got       = 1'b1;
        break;
      end
    end
    if (!got) o.timeout = 1'b1;
    if (drop) begin
      cpu_req = 1'b0;
      dma_req = 1'b0;
    end
    @(posedge clk); #1;
    o.ack_wide = cpu_ack | dma_ack;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs",
        {mem_r, mem_w, grant, cpu_ack, dma_ack, cpu_rdata, dma_rdata, mem_addr, mem_wdata},
        64'h0);
    reset      = 1'b0;
    m_last_dma = 1'b1;
    m_cpu_rd   = '0;
    m_dma_rd   = '0;
  endtask

  typedef struct {
    bit          creq; bit cwe; logic [15:0] caddr; logic [7:0] cwd;
    bit          dreq; bit dwe; logic [15:0] daddr; logic [7:0] dwd;
    logic [7:0]  mdata;
    logic [1:0]  egrant;
    bit          eread;
    logic [15:0] eaddr;
    logic [7:0]  ewd;
    logic [7:0]  ecpu_rd;
    logic [7:0]  edma_rd;
  } vec_t;

  vec_t vecs[7];
  obs_t o;

  initial begin
    use_hash = 1'b0; mem_data = '0;
    u1_cpu_req = 1'b0; u1_cpu_we = 1'b0; u1_cpu_addr = '0; u1_cpu_wdata = '0;
    u1_dma_req = 1'b0; u1_dma_we = 1'b0; u1_dma_addr = '0; u1_dma_wdata = '0;

    //           creq cwe caddr     cwd    dreq dwe daddr     dwd    mdata  grant  rd  eaddr     ewd    cpu_rd dma_rd
    vecs[0] = '{1'b1, 1'b0, 16'h2000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hA5, 2'b01, 1'b1, 16'h2000, 8'h00, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h1F00, 8'h3C, 8'hEE, 2'b10, 1'b0, 16'h1F00, 8'h3C, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0042, 8'h00, 8'h77, 2'b10, 1'b1, 16'h0042, 8'h00, 8'hA5, 8'h77};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h12, 2'b01, 1'b0, 16'hFFFF, 8'hFF, 8'hA5, 8'h77};
    // Tie after a CPU grant: DMA wins under both policies.
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 1'b0, 16'h4321, 8'h00, 8'h11, 2'b10, 1'b1, 16'h4321, 8'h00, 8'hA5, 8'h11};
`ifdef BUS_ARB_ROUND_ROBIN_EN
    vecs[5] = '{1'b1, 1'b1, 16'h0001, 8'h99, 1'b1, 1'b1, 16'h0002, 8'h88, 8'h00, 2'b01, 1'b0, 16'h0001, 8'h99, 8'hA5, 8'h11};
`else
    vecs[5] = '{1'b1, 1'b1, 16'h0001, 8'h99, 1'b1, 1'b1, 16'h0002, 8'h88, 8'h00, 2'b10, 1'b0, 16'h0002, 8'h88, 8'hA5, 8'h11};
`endif
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 2'b01, 1'b1, 16'h0000, 8'h00, 8'h00, 8'h11};

    do_reset();

    // Directed vectors
    foreach (vecs[i]) begin
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
      dma_req = vecs[i].dreq; dma_we = vecs[i].dwe; dma_addr = vecs[i].daddr; dma_wdata = vecs[i].dwd;
      mem_data = vecs[i].mdata;
      xfer(1'b1, 1'b0, o);
      chk($sformatf("vec%0d timeout", i), 64'(o.timeout), 64'd0);
      chk($sformatf("vec%0d grant", i), 64'(o.grant), 64'(vecs[i].egrant));
      chk($sformatf("vec%0d strobe r/w", i), 64'({o.r, o.w}), 64'({vecs[i].eread, !vecs[i].eread}));
      chk($sformatf("vec%0d addr", i), 64'(o.addr), 64'(vecs[i].eaddr));
      if (!vecs[i].eread) chk($sformatf("vec%0d wdata", i), 64'(o.wdata), 64'(vecs[i].ewd));
      chk($sformatf("vec%0d latency", i), 64'(o.lat), 64'd1);
      chk($sformatf("vec%0d strobe cycles", i), 64'(o.strobes), 64'(AC));
      chk($sformatf("vec%0d bus stable", i), 64'(o.stable), 64'd1);
      chk($sformatf("vec%0d ack", i), 64'(o.ack), 64'(vecs[i].egrant));
      chk($sformatf("vec%0d ack width", i), 64'(o.ack_wide), 64'd0);
      chk($sformatf("vec%0d cpu_rdata", i), 64'(cpu_rdata), 64'(vecs[i].ecpu_rd));
      chk($sformatf("vec%0d dma_rdata", i), 64'(dma_rdata), 64'(vecs[i].edma_rd));
    end

    // Continuous contention: grant pattern and transfer spacing
    do_reset();
    use_hash = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h42;
    begin
      int prev;
      logic [1:0] eg;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
        xfer(1'b0, 1'b0, o);
`ifdef BUS_ARB_ROUND_ROBIN_EN
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
        eg = 2'b10;
`endif
        chk($sformatf("contend%0d grant", i), 64'(o.grant), 64'(eg));
        chk($sformatf("contend%0d ack", i), 64'(o.ack), 64'(eg));
        if (i > 0) chk($sformatf("contend%0d spacing", i), 64'(o.ack_cyc - prev), 64'(AC + 2));
        prev = o.ack_cyc;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    chk("contend cpu_rdata", 64'(cpu_rdata), 64'(hash8(16'h0100)));
`else
    chk("contend cpu_rdata", 64'(cpu_rdata), 64'h00);
`endif
    @(posedge clk); #1;

    // Reset during the first strobe cycle aborts the transfer
    use_hash = 1'b0; mem_data = 8'h5C;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    xfer(1'b1, 1'b0, o);
    chk("pre-abort cpu_rdata", 64'(cpu_rdata), 64'h5C);
    cpu_req = 1'b1; cpu_addr = 16'h3001; mem_data = 8'h66;
    @(posedge clk); #1;
    chk("abort first strobe", 64'(mem_r), 64'd1);
    reset = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort outputs", 64'({mem_r, mem_w, grant, cpu_ack, dma_ack}), 64'd0);
    chk("abort cpu_rdata cleared", 64'(cpu_rdata), 64'h00);
    reset = 1'b0;
    begin
      int act;
      act = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (cpu_ack || dma_ack || mem_r || mem_w) act++;
      end
      chk("abort no ack", 64'(act), 64'd0);
    end
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0F0F; mem_data = 8'hE1;
    xfer(1'b1, 1'b0, o);
    chk("post-abort latency", 64'(o.lat), 64'd1);
    chk("post-abort ack", 64'(o.ack), 64'(2'b10));
    chk("post-abort dma_rdata", 64'(dma_rdata), 64'hE1);

    // ACCESS_CYCLES=1: back-to-back CPU reads
    do_reset();
    u1_cpu_req = 1'b1; u1_cpu_we = 1'b0; u1_cpu_addr = 16'hABCD; u1_cpu_wdata = 8'h17;
    begin
      logic [11:0] obs_s, obs_a, exp_s, exp_a;
      int bad, off;
      bad = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        obs_s[k-1] = u1_mem_r;
        obs_a[k-1] = u1_cpu_ack;
        off = (k - 1) % (AC1 + 2);
        exp_s[k-1] = (off < AC1);
        exp_a[k-1] = (off == AC1);
        if (u1_mem_w || u1_dma_ack) bad++;
        if (u1_mem_r && (u1_grant !== 2'b01 || u1_mem_addr !== 16'hABCD || u1_mem_wdata !== 8'h17)) bad++;
      end
      u1_cpu_req = 1'b0;
      chk("ac1 strobe pattern", 64'(obs_s), 64'(exp_s));
      chk("ac1 ack pattern", 64'(obs_a), 64'(exp_a));
      chk("ac1 bus contents", 64'(bad), 64'd0);
      chk("ac1 cpu_rdata", 64'(u1_cpu_rdata), 64'(hash8(16'hABCD)));
      chk("ac1 dma_rdata", 64'(u1_dma_rdata), 64'h00);
    end

    // Randomized transfers against the transaction model
    do_reset();
    use_hash = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int kind;
      bit win_dma, ewe;
      logic [15:0] eaddr;
      logic [7:0]  ewd;
      kind      = int'($urandom_range(0, 2));
      cpu_req   = (kind != 1);
      dma_req   = (kind != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      dma_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom);
      dma_addr  = 16'($urandom);
      cpu_wdata = 8'($urandom);
      dma_wdata = 8'($urandom);
      win_dma = model_pick_dma(cpu_req, dma_req);
      ewe     = win_dma ? dma_we : cpu_we;
      eaddr   = win_dma ? dma_addr : cpu_addr;
      ewd     = win_dma ? dma_wdata : cpu_wdata;
      xfer(1'b1, 1'b1, o);
      m_last_dma = win_dma;
      if (!ewe) begin
        if (win_dma) m_dma_rd = hash8(eaddr);
        else         m_cpu_rd = hash8(eaddr);
      end
      chk($sformatf("rnd%0d timeout", i), 64'(o.timeout), 64'd0);
      chk($sformatf("rnd%0d grant", i), 64'(o.grant), win_dma ? 64'd2 : 64'd1);
      chk($sformatf("rnd%0d addr", i), 64'(o.addr), 64'(eaddr));
      chk($sformatf("rnd%0d strobe r/w", i), 64'({o.r, o.w}), 64'({!ewe, ewe}));
      if (ewe) chk($sformatf("rnd%0d wdata", i), 64'(o.wdata), 64'(ewd));
      chk($sformatf("rnd%0d timing", i), 64'({o.lat[7:0], o.strobes[7:0]}), 64'({8'd1, 8'(AC)}));
      chk($sformatf("rnd%0d stable/excl", i), 64'({o.stable, o.both}), 64'(2'b10));
      chk($sformatf("rnd%0d ack", i), 64'(o.ack), win_dma ? 64'd2 : 64'd1);
      chk($sformatf("rnd%0d cpu_rdata", i), 64'(cpu_rdata), 64'(m_cpu_rd));
      chk($sformatf("rnd%0d dma_rdata", i), 64'(dma_rdata), 64'(m_dma_rd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
